// File: rtl/m68k_bus_pkg.sv
// -----------------------------------------------------------------------------
// m68k_bus_pkg
// Shared definitions for the 68000-style bus cycle sequencer:
//   - bus_state_e   : sequencer states (IDLE, ARM, S0..S4, SW, S5..S7)
//   - bus_ctl_t     : bundle of the registered bus control outputs
//   - BUS_CTL_IDLE  : strobe/control levels when no cycle is running
//   - TIMEOUT_DEFAULT, SYNC_STAGES_DEFAULT : parameter defaults
// -----------------------------------------------------------------------------
package m68k_bus_pkg;

  typedef enum logic [3:0] {
    IDLE,
    ARM,
    S0,
    S1,
    S2,
    S3,
    S4,
    SW,
    S5,
    S6,
    S7
  } bus_state_e;

  typedef struct packed {
    logic as_n;
    logic uds_n;
    logic lds_n;
    logic rnw;
    logic data_oe;
  } bus_ctl_t;

  // All strobes deasserted, bus in read direction, data bus not driven.
  localparam bus_ctl_t BUS_CTL_IDLE = '{
    as_n:    1'b1,
    uds_n:   1'b1,
    lds_n:   1'b1,
    rnw:     1'b1,
    data_oe: 1'b0
  };

  localparam int TIMEOUT_DEFAULT     = 255;
  localparam int SYNC_STAGES_DEFAULT = 2;

endpackage

// File: rtl/m68k_bus_cycle_seq_edge.sv
// -----------------------------------------------------------------------------
// c7m_edge_detect
// Multi-flop synchroniser for one asynchronous input, followed by one history
// register so rising/falling edges of the synchronised level can be flagged.
// Ports:
//   CLK           in  high-speed clock
//   clocked_reset in  asynchronous, active-high reset
//   din           in  raw asynchronous input
//   dout          out synchronised level (SYNC_STAGES flops deep)
//   rise          out synchronised level went 0 -> 1 this cycle (combinational)
//   fall          out synchronised level went 1 -> 0 this cycle (combinational)
// A consumer that registers its reaction to rise/fall sees a fixed latency of
// SYNC_STAGES+1 CLK from the raw edge. SYNC_STAGES must be at least 2.
// -----------------------------------------------------------------------------
module c7m_edge_detect
  import m68k_bus_pkg::*;
#(
  parameter int   SYNC_STAGES = SYNC_STAGES_DEFAULT,
  parameter logic RST_VAL     = 1'b0
) (
  input  logic CLK,
  input  logic clocked_reset,
  input  logic din,
  output logic dout,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   prev_q, prev_d;

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], din};
    prev_d = sync_q[SYNC_STAGES-1];
  end

  // NOTE: every flop, synchroniser stages included, gets an explicit reset
  // value so the edge history starts from a known level after reset.
  always_ff @(posedge CLK or posedge clocked_reset) begin
    if (clocked_reset) begin
      sync_q <= {SYNC_STAGES{RST_VAL}};
      prev_q <= RST_VAL;
    end else begin
      // NOTE: non-blocking assignments keep each stage sampling the value the
      // previous stage held before this edge, which is what makes a chain.
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign dout = sync_q[SYNC_STAGES-1];
  assign rise =  dout & ~prev_q;
  assign fall = ~dout &  prev_q;

endmodule

// File: rtl/m68k_bus_cycle_seq.sv
// -----------------------------------------------------------------------------
// m68k_bus_cycle_seq
// Runs one 68000-style asynchronous bus cycle (read/write, byte/word) in the
// CLK domain, stepping S0..S7 on synchronised edges of the CPU clock c7m.
// Ports:
//   CLK, clocked_reset         high-speed clock, async active-high reset
//   c7m                        raw CPU clock (asynchronous)
//   req_valid/req_ready        request handshake (ready only in IDLE)
//   req_rnw, req_uds, req_lds  request attributes captured at handshake
//   dtack_n, berr_n            raw bus acknowledge / bus error (async, low)
//   as_n, uds_n, lds_n, rnw    registered bus strobes
//   data_oe                    drive the data bus (writes only)
//   rdata_latch                one-CLK pulse: capture read data
//   rsp_valid, rsp_err         one-CLK completion pulse and its error flag
// All bus outputs are registered, so every change lands SYNC_STAGES+1 CLK
// after the c7m edge that caused it.
// -----------------------------------------------------------------------------
module m68k_bus_cycle_seq
  import m68k_bus_pkg::*;
#(
  parameter int SYNC_STAGES = SYNC_STAGES_DEFAULT,
  parameter int TIMEOUT     = TIMEOUT_DEFAULT
) (
  input  logic CLK,
  input  logic clocked_reset,
  input  logic c7m,
  input  logic req_valid,
  output logic req_ready,
  input  logic req_rnw,
  input  logic req_uds,
  input  logic req_lds,
  input  logic dtack_n,
  input  logic berr_n,
  output logic as_n,
  output logic uds_n,
  output logic lds_n,
  output logic rnw,
  output logic data_oe,
  output logic rdata_latch,
  output logic rsp_valid,
  output logic rsp_err
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  // ---------------------------------------------------------------------------
  // Synchronisers. dtack_n/berr_n use the same depth as c7m so that their
  // sampled level lines up with the c7m falling edge on which they are judged.
  // ---------------------------------------------------------------------------
  logic c7m_sync_unused, c7m_rise, c7m_fall;
  logic dtack_n_s, dtack_rise_unused, dtack_fall_unused;
  logic berr_n_s, berr_rise_unused, berr_fall_unused;

  c7m_edge_detect #(
    .SYNC_STAGES(SYNC_STAGES),
    .RST_VAL    (1'b0)
  ) u_c7m_edge (
    .CLK          (CLK),
    .clocked_reset(clocked_reset),
    .din          (c7m),
    .dout         (c7m_sync_unused),
    .rise         (c7m_rise),
    .fall         (c7m_fall)
  );

  // Active-low inputs are parked at their deasserted level during reset.
  c7m_edge_detect #(
    .SYNC_STAGES(SYNC_STAGES),
    .RST_VAL    (1'b1)
  ) u_dtack_sync (
    .CLK          (CLK),
    .clocked_reset(clocked_reset),
    .din          (dtack_n),
    .dout         (dtack_n_s),
    .rise         (dtack_rise_unused),
    .fall         (dtack_fall_unused)
  );

  c7m_edge_detect #(
    .SYNC_STAGES(SYNC_STAGES),
    .RST_VAL    (1'b1)
  ) u_berr_sync (
    .CLK          (CLK),
    .clocked_reset(clocked_reset),
    .din          (berr_n),
    .dout         (berr_n_s),
    .rise         (berr_rise_unused),
    .fall         (berr_fall_unused)
  );

  // ---------------------------------------------------------------------------
  // Sequencer state
  // ---------------------------------------------------------------------------
  bus_state_e       state_q, state_d;
  bus_ctl_t         ctl_q, ctl_d;
  logic             rnw_cap_q, rnw_cap_d;
  logic             uds_cap_q, uds_cap_d;
  logic             lds_cap_q, lds_cap_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] cnt_inc;
  logic             rdata_latch_q, rdata_latch_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic             rsp_err_q, rsp_err_d;

  // NOTE: every signal written here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d       = state_q;
    ctl_d         = ctl_q;
    rnw_cap_d     = rnw_cap_q;
    uds_cap_d     = uds_cap_q;
    lds_cap_d     = lds_cap_q;
    err_d         = err_q;
    cnt_d         = cnt_q;
    cnt_inc       = cnt_q + CNT_W'(1);
    rdata_latch_d = 1'b0;
    rsp_valid_d   = 1'b0;
    rsp_err_d     = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          rnw_cap_d = req_rnw;
          uds_cap_d = req_uds;
          lds_cap_d = req_lds;
          err_d     = 1'b0;
          cnt_d     = '0;
          state_d   = ARM;
        end
      end

      ARM: begin
        // An empty byte mask never touches the bus: report it immediately.
        if (!uds_cap_q && !lds_cap_q) begin
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
          state_d     = IDLE;
        end else if (c7m_rise) begin
          ctl_d.rnw = rnw_cap_q;
          state_d   = S0;
        end
      end

      S0: if (c7m_fall) state_d = S1;

      S1: begin
        if (c7m_rise) begin
          ctl_d.as_n = 1'b0;
          if (rnw_cap_q) begin
            ctl_d.uds_n = ~uds_cap_q;
            ctl_d.lds_n = ~lds_cap_q;
          end
          state_d = S2;
        end
      end

      S2: begin
        if (c7m_fall) begin
          if (!rnw_cap_q) ctl_d.data_oe = 1'b1;
          state_d = S3;
        end
      end

      S3: begin
        // Write data strobes wait until the data bus has been driven.
        if (c7m_rise) begin
          if (!rnw_cap_q) begin
            ctl_d.uds_n = ~uds_cap_q;
            ctl_d.lds_n = ~lds_cap_q;
          end
          state_d = S4;
        end
      end

      S4: begin
        // berr wins when both are seen on the same sample.
        if (c7m_fall) begin
          if (!berr_n_s) begin
            err_d   = 1'b1;
            state_d = S5;
          end else if (!dtack_n_s) begin
            state_d = S5;
          end else begin
            state_d = SW;
          end
        end
      end

      SW: begin
        if (c7m_fall) begin
          if (!berr_n_s) begin
            err_d   = 1'b1;
            state_d = S5;
          end else if (!dtack_n_s) begin
            state_d = S5;
          end else begin
            cnt_d = cnt_inc;
            if (cnt_inc == CNT_W'(TIMEOUT)) begin
              err_d   = 1'b1;
              state_d = S5;
            end
          end
        end
      end

      S5: if (c7m_rise) state_d = S6;

      S6: begin
        if (c7m_fall) begin
          rdata_latch_d = rnw_cap_q & ~err_q;
          state_d       = S7;
        end
      end

      S7: begin
        if (c7m_rise) begin
          ctl_d       = BUS_CTL_IDLE;
          rsp_valid_d = 1'b1;
          rsp_err_d   = err_q;
          cnt_d       = '0;
          err_d       = 1'b0;
          state_d     = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge clocked_reset) begin
    if (clocked_reset) begin
      state_q       <= IDLE;
      ctl_q         <= BUS_CTL_IDLE;
      rnw_cap_q     <= 1'b1;
      uds_cap_q     <= 1'b0;
      lds_cap_q     <= 1'b0;
      err_q         <= 1'b0;
      cnt_q         <= '0;
      rdata_latch_q <= 1'b0;
      rsp_valid_q   <= 1'b0;
      rsp_err_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      ctl_q         <= ctl_d;
      rnw_cap_q     <= rnw_cap_d;
      uds_cap_q     <= uds_cap_d;
      lds_cap_q     <= lds_cap_d;
      err_q         <= err_d;
      cnt_q         <= cnt_d;
      rdata_latch_q <= rdata_latch_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_err_q     <= rsp_err_d;
    end
  end

  assign req_ready   = (state_q == IDLE);
  assign as_n        = ctl_q.as_n;
  assign uds_n       = ctl_q.uds_n;
  assign lds_n       = ctl_q.lds_n;
  assign rnw         = ctl_q.rnw;
  assign data_oe     = ctl_q.data_oe;
  assign rdata_latch = rdata_latch_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_err     = rsp_err_q;

endmodule

// File: tb/tb_m68k_bus_cycle_seq.sv
// -----------------------------------------------------------------------------
// tb_m68k_bus_cycle_seq
// Two sequencers share CLK, c7m, dtack_n and berr_n: u_a uses the default
// TIMEOUT, u_b uses TIMEOUT=3. Only one is ever busy, so their bus outputs are
// merged and watched by a single monitor. The driver pushes the expected
// response of each request into a queue; the monitor tracks strobe activity
// and pops/compares when rsp_valid appears.
// c7m half period is H CLK cycles and toggles on the CLK falling edge.
// -----------------------------------------------------------------------------
module tb_m68k_bus_cycle_seq;

  localparam int H = 5;      // c7m half period in CLK cycles
  localparam int P = 2 * H;  // c7m period in CLK cycles
  localparam int LAT = 3;    // SYNC_STAGES + 1

  typedef struct {
    int err;
    int latches;
    int as_low;   // CLK cycles as_n is low, -1 = as_n never asserted
    int uds_low;
    int lds_low;
    int oe;
    int lag;      // as_n fall to data strobe fall, -1 = no strobe
    int rnw;
    int rsp_cyc;  // absolute cycle of rsp_valid, used for empty mask only
  } exp_t;

  logic CLK = 1'b0;
  logic clocked_reset = 1'b1;
  logic c7m = 1'b0;
  logic req_valid_a = 1'b0, req_valid_b = 1'b0;
  logic req_rnw = 1'b1, req_uds = 1'b0, req_lds = 1'b0;
  logic dtack_n = 1'b0, berr_n = 1'b1;

  logic req_ready_a, as_n_a, uds_n_a, lds_n_a, rnw_a, data_oe_a;
  logic rdata_latch_a, rsp_valid_a, rsp_err_a;
  logic req_ready_b, as_n_b, uds_n_b, lds_n_b, rnw_b, data_oe_b;
  logic rdata_latch_b, rsp_valid_b, rsp_err_b;

  m68k_bus_cycle_seq #(.SYNC_STAGES(2)) u_a (
    .CLK(CLK), .clocked_reset(clocked_reset), .c7m(c7m),
    .req_valid(req_valid_a), .req_ready(req_ready_a),
    .req_rnw(req_rnw), .req_uds(req_uds), .req_lds(req_lds),
    .dtack_n(dtack_n), .berr_n(berr_n),
    .as_n(as_n_a), .uds_n(uds_n_a), .lds_n(lds_n_a), .rnw(rnw_a),
    .data_oe(data_oe_a), .rdata_latch(rdata_latch_a),
    .rsp_valid(rsp_valid_a), .rsp_err(rsp_err_a)
  );

  m68k_bus_cycle_seq #(.SYNC_STAGES(2), .TIMEOUT(3)) u_b (
    .CLK(CLK), .clocked_reset(clocked_reset), .c7m(c7m),
    .req_valid(req_valid_b), .req_ready(req_ready_b),
    .req_rnw(req_rnw), .req_uds(req_uds), .req_lds(req_lds),
    .dtack_n(dtack_n), .berr_n(berr_n),
    .as_n(as_n_b), .uds_n(uds_n_b), .lds_n(lds_n_b), .rnw(rnw_b),
    .data_oe(data_oe_b), .rdata_latch(rdata_latch_b),
    .rsp_valid(rsp_valid_b), .rsp_err(rsp_err_b)
  );

  wire as_n_w        = as_n_a & as_n_b;
  wire uds_n_w       = uds_n_a & uds_n_b;
  wire lds_n_w       = lds_n_a & lds_n_b;
  wire rnw_w         = rnw_a & rnw_b;
  wire data_oe_w     = data_oe_a | data_oe_b;
  wire rdata_latch_w = rdata_latch_a | rdata_latch_b;
  wire rsp_valid_w   = rsp_valid_a | rsp_valid_b;
  wire rsp_err_w     = (rsp_valid_a & rsp_err_a) | (rsp_valid_b & rsp_err_b);

  always #5 CLK = ~CLK;

  int ph = 0;
  always @(negedge CLK) begin
    if (ph == H - 1) begin
      ph  <= 0;
      c7m <= ~c7m;
    end else begin
      ph <= ph + 1;
    end
  end

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  int   n_cmp = 0;
  int   n_bad = 0;
  exp_t q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: actual %0d required %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic exp_t mk(input int err, latches, as_low, uds_low, lds_low, oe, lag, r);
    exp_t e;
    e.err = err; e.latches = latches; e.as_low = as_low;
    e.uds_low = uds_low; e.lds_low = lds_low; e.oe = oe;
    e.lag = lag; e.rnw = r; e.rsp_cyc = -1;
    return e;
  endfunction

  // ---------------------------------------------------------------------------
  // Monitor: samples 1 time unit after every rising CLK edge.
  // ---------------------------------------------------------------------------
  int   age = 0;
  logic c7m_p = 1'b0, as_p = 1'b1, uds_p = 1'b1, lds_p = 1'b1, oe_p = 1'b0, rnw_p = 1'b1;
  int   as_seen, uds_seen, lds_seen, oe_seen, latch_cnt;
  int   as_fall, uds_fall, lds_fall, oe_rise, latch_cyc;

  task automatic clear_track();
    as_seen = 0; uds_seen = 0; lds_seen = 0; oe_seen = 0; latch_cnt = 0;
    as_fall = 0; uds_fall = 0; lds_fall = 0; oe_rise = 0; latch_cyc = 0;
  endtask

  initial begin
    exp_t e;
    clear_track();
    forever begin
      @(posedge CLK);
      #1;
      age = (c7m !== c7m_p) ? 1 : age + 1;
      if (clocked_reset) begin
        clear_track();
      end else begin
        if (as_n_w !== as_p) begin
          check("as_edge_latency", age, LAT);
          if (!as_n_w) begin
            as_seen = 1;
            as_fall = cyc;
            if (q.size() > 0) check("rnw_during_as", rnw_w, q[0].rnw);
          end
        end
        if (uds_n_w !== uds_p) begin
          check("uds_edge_latency", age, LAT);
          if (!uds_n_w) begin uds_seen = 1; uds_fall = cyc; end
        end
        if (lds_n_w !== lds_p) begin
          check("lds_edge_latency", age, LAT);
          if (!lds_n_w) begin lds_seen = 1; lds_fall = cyc; end
        end
        if (data_oe_w !== oe_p) begin
          check("oe_edge_latency", age, LAT);
          if (data_oe_w) begin oe_seen = 1; oe_rise = cyc; end
        end
        if (rnw_w !== rnw_p) check("rnw_edge_latency", age, LAT);
        if (rdata_latch_w) begin
          check("latch_edge_latency", age, LAT);
          latch_cnt++;
          latch_cyc = cyc;
        end
        if (rsp_valid_w) begin
          if (q.size() == 0) begin
            check("unexpected_rsp", 1, 0);
          end else begin
            e = q.pop_front();
            check("rsp_err", rsp_err_w, e.err);
            check("latch_count", latch_cnt, e.latches);
            if (e.as_low < 0) begin
              check("empty_as_never", as_seen, 0);
              check("empty_rsp_cycle", cyc, e.rsp_cyc);
            end else begin
              check("rsp_edge_latency", age, LAT);
              check("as_low_clks", cyc - as_fall, e.as_low);
              check("uds_low", uds_seen, e.uds_low);
              check("lds_low", lds_seen, e.lds_low);
              check("oe_seen", oe_seen, e.oe);
              if (e.lag >= 0)
                check("strobe_lag", (e.lds_low != 0 ? lds_fall : uds_fall) - as_fall, e.lag);
              if (e.oe != 0) check("oe_lag", oe_rise - as_fall, H);
              if (e.latches > 0) check("latch_pos", cyc - latch_cyc, H);
              check("bus_idle_at_end", {as_n_w, uds_n_w, lds_n_w, rnw_w, data_oe_w}, 5'b11110);
            end
          end
          clear_track();
        end
      end
      c7m_p = c7m; as_p = as_n_w; uds_p = uds_n_w; lds_p = lds_n_w;
      oe_p = data_oe_w; rnw_p = rnw_w;
    end
  end

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  task automatic issue(input int which, input logic r, u, l, input exp_t e_in, input bit push);
    exp_t e;
    int   n;
    logic rdy;
    e = e_in;
    @(posedge CLK);
    #1;
    n = 0;
    rdy = (which == 0) ? req_ready_a : req_ready_b;
    while (rdy !== 1'b1 && n < 2000) begin
      @(posedge CLK);
      #1;
      n++;
      rdy = (which == 0) ? req_ready_a : req_ready_b;
    end
    check("req_ready_wait", rdy, 1);
    req_rnw = r; req_uds = u; req_lds = l;
    if (which == 0) req_valid_a = 1'b1;
    else            req_valid_b = 1'b1;
    e.rsp_cyc = cyc + 2;
    if (push) q.push_back(e);
    @(posedge CLK);
    #1;
    req_valid_a = 1'b0;
    req_valid_b = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((q.size() != 0 || req_ready_a !== 1'b1 || req_ready_b !== 1'b1) && n < 5000) begin
      @(posedge CLK);
      #1;
      n++;
    end
    check("drain_queue", q.size(), 0);
  endtask

  task automatic wait_as_low();
    int n = 0;
    while (as_n_w !== 1'b0 && n < 500) begin
      @(posedge CLK);
      #1;
      n++;
    end
    check("as_asserted", as_n_w, 0);
  endtask

  task automatic check_idle_outputs(input string name);
    check({name, "_a"}, {req_ready_a, as_n_a, uds_n_a, lds_n_a, rnw_a, data_oe_a,
                         rdata_latch_a, rsp_valid_a, rsp_err_a}, 9'b111110000);
    check({name, "_b"}, {req_ready_b, as_n_b, uds_n_b, lds_n_b, rnw_b, data_oe_b,
                         rdata_latch_b, rsp_valid_b, rsp_err_b}, 9'b111110000);
  endtask

  // ---------------------------------------------------------------------------
  // Directed stimulus
  // ---------------------------------------------------------------------------
  initial begin
    repeat (4) @(posedge CLK);
    #1;
    check_idle_outputs("reset_state");
    #1 clocked_reset = 1'b0;
    repeat (10) @(posedge CLK);

    // Word read, dtack low throughout.
    issue(0, 1'b1, 1'b1, 1'b1, mk(0, 1, 3 * P, 1, 1, 0, 0, 1), 1'b1);
    wait_idle();

    // Byte write, lower lane only: lds_n one CPU clock after as_n.
    issue(0, 1'b0, 1'b0, 1'b1, mk(0, 0, 3 * P, 0, 1, 1, P, 0), 1'b1);
    wait_idle();

    // Upper-byte read.
    issue(0, 1'b1, 1'b1, 1'b0, mk(0, 1, 3 * P, 1, 0, 0, 0, 1), 1'b1);
    wait_idle();

    // Read with dtack 4 CPU clocks late: 4 SW iterations.
    dtack_n = 1'b1;
    issue(0, 1'b1, 1'b1, 1'b1, mk(0, 1, 7 * P, 1, 1, 0, 0, 1), 1'b1);
    wait_as_low();
    repeat (5) @(negedge c7m);
    #20 dtack_n = 1'b0;
    wait_idle();

    // dtack never asserted on the TIMEOUT=3 instance.
    dtack_n = 1'b1;
    issue(1, 1'b1, 1'b1, 1'b1, mk(1, 0, 6 * P, 1, 1, 0, 0, 1), 1'b1);
    wait_idle();
    dtack_n = 1'b0;

    // berr and dtack together: error, no read latch, full S5..S7.
    berr_n = 1'b0;
    issue(0, 1'b1, 1'b1, 1'b1, mk(1, 0, 3 * P, 1, 1, 0, 0, 1), 1'b1);
    wait_idle();
    berr_n = 1'b1;

    // Reset while waiting in SW: no response, bus released immediately.
    dtack_n = 1'b1;
    issue(0, 1'b1, 1'b1, 1'b1, mk(0, 0, 0, 0, 0, 0, -1, 1), 1'b0);
    wait_as_low();
    repeat (4) @(negedge c7m);
    #3 clocked_reset = 1'b1;
    #1;
    check_idle_outputs("reset_mid_cycle");
    repeat (3) @(posedge CLK);
    #2 clocked_reset = 1'b0;
    dtack_n = 1'b0;
    repeat (10) @(posedge CLK);

    // Next request after reset runs normally.
    issue(0, 1'b1, 1'b1, 1'b1, mk(0, 1, 3 * P, 1, 1, 0, 0, 1), 1'b1);
    wait_idle();

    // Empty mask: immediate error response, no bus activity.
    issue(0, 1'b1, 1'b0, 1'b0, mk(1, 0, -1, 0, 0, 0, -1, 1), 1'b1);
    wait_idle();

    repeat (20) @(posedge CLK);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
